// File: rtl/rattlesnake_trap_ctl_pkg.sv
// Shared definitions for the rattlesnake trap controller: FSM states, interrupt
// cause codes, mtvec modes and the captured trap record.
package rattlesnake_trap_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_REDIR = 2'd2,
        ST_DRAIN = 2'd3
    } trap_state_e;

    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Everything the CSR file needs for mcause/mepc/mtval, held until the next trap.
    typedef struct packed {
        logic        is_interrupt;
        logic [3:0]  code;
        logic [31:0] pc;
        logic [31:0] addr;
    } trap_info_t;

    function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
        return {mtvec[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rattlesnake_trap_ctl_if.sv
// Pipeline/CSR side of the trap controller; the controller uses the slave modport,
// the pipeline and CSR file (or a bench) use the master modport.
interface rattlesnake_trap_ctl_if;

    logic        instr_retire;
    logic [31:0] next_pc;
    logic        sync_exc_valid;
    logic [3:0]  sync_exc_code;
    logic [31:0] sync_exc_pc;
    logic [31:0] sync_exc_addr;
    logic        mret_valid;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        mie_in;
    logic        mtie_in;
    logic        meie_in;
    logic        mtip_in;
    logic        meip_in;

    logic        activate_exception;
    logic        is_interrupt;
    logic [3:0]  exception_code;
    logic [31:0] exception_PC;
    logic [31:0] exception_addr;
    logic        csr_mret_active;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_req;
    logic        in_handler;

    modport master (
        output instr_retire, next_pc, sync_exc_valid, sync_exc_code, sync_exc_pc,
               sync_exc_addr, mret_valid, mtvec_in, mepc_in, mie_in, mtie_in,
               meie_in, mtip_in, meip_in,
        input  activate_exception, is_interrupt, exception_code, exception_PC,
               exception_addr, csr_mret_active, redirect_valid, redirect_pc,
               stall_req, in_handler
    );

    modport slave (
        input  instr_retire, next_pc, sync_exc_valid, sync_exc_code, sync_exc_pc,
               sync_exc_addr, mret_valid, mtvec_in, mepc_in, mie_in, mtie_in,
               meie_in, mtip_in, meip_in,
        output activate_exception, is_interrupt, exception_code, exception_PC,
               exception_addr, csr_mret_active, redirect_valid, redirect_pc,
               stall_req, in_handler
    );

endinterface

// File: rtl/rattlesnake_trap_target.sv
// Trap-entry fetch target from mtvec. Define TRAP_VECTORED_EN to honour vectored
// mode for interrupts; otherwise every trap enters at the direct base.
module rattlesnake_trap_target
    import rattlesnake_trap_ctl_pkg::*;
(
    input  logic [31:0] mtvec_i,
    input  logic [3:0]  code_i,
    input  logic        is_interrupt_i,
    output logic [31:0] target_pc_o
);

`ifdef TRAP_VECTORED_EN
    always_comb begin
        target_pc_o = mtvec_base(mtvec_i);
        // Exceptions always land on the base, even with a vectored mtvec.
        if ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && is_interrupt_i) begin
            target_pc_o = mtvec_base(mtvec_i) + {26'd0, code_i, 2'b00};
        end
    end
`else
    logic unused_target_inputs;

    assign target_pc_o          = mtvec_base(mtvec_i);
    assign unused_target_inputs = ^{code_i, is_interrupt_i};
`endif

endmodule

// File: rtl/rattlesnake_trap_ctl.sv
// Trap controller: arbitrates exceptions, interrupts and MRET, drives the CSR
// pulses, the fetch redirect and the pipeline stall. Optional macro: TRAP_VECTORED_EN.
module rattlesnake_trap_ctl
    import rattlesnake_trap_ctl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sync_reset,
    rattlesnake_trap_ctl_if.slave        bus
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    trap_state_e state_q;
    logic [3:0]  drain_cnt_q;
    logic        in_handler_q;
    logic        activate_q;
    logic        mret_active_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        stall_q;
    trap_info_t  trap_q;
    trap_info_t  trap_d;
    logic        take_trap;
    logic        irq_gate;
    logic [31:0] target_pc_d;

    // Interrupts are only taken at an instruction boundary and never inside the handler.
    assign irq_gate = bus.mie_in & bus.instr_retire & ~in_handler_q;

    // NOTE: defaults first so every path assigns take_trap/trap_d and no latch is inferred.
    always_comb begin
        take_trap = 1'b1;
        trap_d    = trap_q;
        if (bus.sync_exc_valid) begin
            trap_d = '{is_interrupt: 1'b0, code: bus.sync_exc_code,
                       pc: bus.sync_exc_pc, addr: bus.sync_exc_addr};
        end else if (irq_gate & bus.meie_in & bus.meip_in) begin
            trap_d = '{is_interrupt: 1'b1, code: IRQ_CODE_EXT, pc: bus.next_pc, addr: '0};
        end else if (irq_gate & bus.mtie_in & bus.mtip_in) begin
            trap_d = '{is_interrupt: 1'b1, code: IRQ_CODE_TIMER, pc: bus.next_pc, addr: '0};
        end else begin
            take_trap = 1'b0;
        end
    end

    rattlesnake_trap_target u_target (
        .mtvec_i        (bus.mtvec_in),
        .code_i         (trap_q.code),
        .is_interrupt_i (trap_q.is_interrupt),
        .target_pc_o    (target_pc_d)
    );

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            drain_cnt_q      <= '0;
            in_handler_q     <= 1'b0;
            activate_q       <= 1'b0;
            mret_active_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_q          <= 1'b0;
            trap_q           <= '0;
        end else if (sync_reset) begin
            state_q          <= ST_IDLE;
            drain_cnt_q      <= '0;
            in_handler_q     <= 1'b0;
            activate_q       <= 1'b0;
            mret_active_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_q          <= 1'b0;
            trap_q           <= '0;
        end else begin
            activate_q       <= 1'b0;
            mret_active_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_trap) begin
                        trap_q       <= trap_d;
                        activate_q   <= 1'b1;
                        in_handler_q <= 1'b1;
                        stall_q      <= 1'b1;
                        state_q      <= ST_TRAP;
                    end else if (bus.mret_valid) begin
                        mret_active_q    <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= bus.mepc_in;
                        in_handler_q     <= 1'b0;
                        stall_q          <= 1'b1;
                        state_q          <= ST_REDIR;
                    end
                end
                ST_TRAP: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target_pc_d;
                    state_q          <= ST_REDIR;
                end
                ST_REDIR: begin
                    drain_cnt_q <= DRAIN_LOAD;
                    state_q     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt_q <= 4'd1) begin
                        drain_cnt_q <= '0;
                        stall_q     <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 4'd1;
                    end
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.activate_exception = activate_q;
    assign bus.is_interrupt       = trap_q.is_interrupt;
    assign bus.exception_code     = trap_q.code;
    assign bus.exception_PC       = trap_q.pc;
    assign bus.exception_addr     = trap_q.addr;
    assign bus.csr_mret_active    = mret_active_q;
    assign bus.redirect_valid     = redirect_valid_q;
    assign bus.redirect_pc        = redirect_pc_q;
    assign bus.stall_req          = stall_q;
    assign bus.in_handler         = in_handler_q;

endmodule

// File: doc/rattlesnake_trap_ctl.md
RATTLESNAKE_TRAP_CTL -- requirements
Module: rattlesnake_trap_ctl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 2, stall cycles held after each redirect (range 1..15).
REQ-002 Ports below, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 sync_reset  in  1  synchronous reset, active-high.
REQ-006 instr_retire  in  1  instruction boundary; an interrupt may be taken this cycle.
REQ-007 next_pc  in  32  PC of the next instruction at the boundary.
REQ-008 sync_exc_valid / sync_exc_code / sync_exc_pc / sync_exc_addr  in  1/4/32/32  synchronous exception request, cause, faulting PC, faulting address.
REQ-009 mret_valid  in  1  MRET decoded.
REQ-010 mtvec_in, mepc_in  in  32 each  current CSR values.
REQ-011 mie_in, mtie_in, meie_in, mtip_in, meip_in  in  1 each  CSR enable and pending bits.
REQ-012 activate_exception, is_interrupt  out  1 each  trap-entry pulse to CSR, interrupt flag.
REQ-013 exception_code, exception_PC, exception_addr  out  4/32/32  values for mcause/mepc/mtval.
REQ-014 csr_mret_active  out  1  MRET-commit pulse to CSR.
REQ-015 redirect_valid, redirect_pc  out  1/32  fetch redirect pulse and target.
REQ-016 stall_req  out  1  pipeline hold.
REQ-017 in_handler  out  1  trap handler active.

Function
REQ-018 FSM states: IDLE, TRAP, REDIR, DRAIN.
REQ-019 Events are sampled only in IDLE, priority: sync_exc_valid > external interrupt > timer interrupt > mret_valid.
REQ-020 External interrupt pending = mie_in & meie_in & meip_in & instr_retire & !in_handler; code 11. Timer = same with mtie_in/mtip_in; code 7.
REQ-021 Trap taken in cycle N: at N+1 activate_exception=1 for exactly one cycle, state TRAP, in_handler<=1.
REQ-022 exception_*: sync exception gives code/pc/addr from sync_exc_*, is_interrupt=0. Interrupt gives exception_PC=next_pc, exception_addr=0, is_interrupt=1. All held stable until the next trap.
REQ-023 At N+2: redirect_valid=1 for one cycle, state REDIR. redirect_pc = {mtvec_in[31:2],2'b00}, with the vectored adjustment in REQ-035.
REQ-024 MRET in cycle N: at N+1 csr_mret_active=1 and redirect_valid=1 with redirect_pc=mepc_in, one cycle; in_handler<=0; state REDIR.
REQ-025 After REDIR: DRAIN for DRAIN_CYCLES cycles (4-bit down-counter), then IDLE.
REQ-026 stall_req=1 in TRAP, REDIR and DRAIN; 0 in IDLE.
REQ-027 Events outside IDLE are ignored and not queued. Interrupts are level-sensitive and re-evaluated on return to IDLE.
REQ-028 sync_exc_valid inside the handler is still taken (nested exception); interrupts are masked while in_handler=1.
REQ-029 Simultaneous sync_exc_valid and mret_valid: the exception wins and in_handler stays 1.

Reset
REQ-030 reset_n low: state IDLE, all outputs 0, counter 0, in_handler 0.
REQ-031 sync_reset high at a clock edge: same values as REQ-030, overriding any event in that cycle.
REQ-032 Reset during TRAP/REDIR/DRAIN aborts the sequence; no pulse is emitted afterwards.

Configuration
REQ-033 Macro TRAP_VECTORED_EN controls vectored trap entry.
REQ-034 Without the macro: mtvec_in[1:0] is ignored and every trap uses direct mode.
REQ-035 With the macro: if mtvec_in[1:0]==2'b01 and is_interrupt=1, redirect_pc = base + 4*exception_code (32-bit, wraps modulo 2^32). Exceptions always use the base.

Structure
REQ-036 The shared package/header holds: FSM state encodings, interrupt codes 7 and 11, and mtvec mode constants.
REQ-037 One sub-module, rattlesnake_trap_target: combinational redirect_pc computation from mtvec, code and is_interrupt.

Verification
REQ-038 sync_exc_valid=1, code=2, pc=0x100, addr=0x0, mtvec=0x200: activate_exception at N+1, redirect_pc=0x200 at N+2, stall_req for 4 cycles.
REQ-039 mie=meie=meip=1, instr_retire=1, next_pc=0x344: is_interrupt=1, code=11, exception_PC=0x344, in_handler=1.
REQ-040 Timer and external interrupt pending together: code 11 is taken first. The timer is not taken until after MRET; then code 7 follows.
REQ-041 With TRAP_VECTORED_EN, mtvec=0x401, timer interrupt: redirect_pc=0x41C. Without the macro: redirect_pc=0x400.
REQ-042 mret_valid with mepc=0x80: csr_mret_active and redirect_valid at N+1, redirect_pc=0x80, in_handler cleared.
REQ-043 reset_n asserted in DRAIN: all outputs 0 immediately; no redirect pulse after release.
